// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: march-style BIST initiator for a dual-port synchronous RAM.
// Each run writes and reads back every address twice: once with the
// incrementing pattern P0(a) = a + 1, once with its complement. It reports
// pass/fail, the first failing location and the total mismatch count.
module ram_bist_ctrl #(
  parameter int unsigned ram_width = 8,
  parameter int unsigned addr_size = 4,
  parameter int unsigned ram_depth = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [addr_size-1:0]   ram_wr_addr,
  output logic [ram_width-1:0]   ram_data_in,
  output logic                   ram_write_en,
  output logic [addr_size-1:0]   ram_rd_addr,
  output logic                   ram_read_en,
  input  logic [ram_width-1:0]   ram_data_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   fail_pass,
  output logic [addr_size-1:0]   fail_addr,
  output logic [ram_width-1:0]   fail_data,
  output logic [addr_size+1:0]   err_count
);

  localparam int unsigned err_width = addr_size + 2;
  localparam logic [addr_size-1:0] last_addr = addr_size'(ram_depth - 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    FLUSH,
    DONE
  } state_t;

  state_t                 state;
  logic                   pass_bit;

  // One-stage compare pipeline: address and expected data of the read
  // captured at the previous edge, checked against ram_data_out now.
  logic                   cmp_valid;
  logic [addr_size-1:0]   cmp_addr;
  logic [ram_width-1:0]   cmp_exp;

  logic                   mismatch_c;
  logic                   first_mismatch_c;
  logic [err_width-1:0]   err_next_c;

  // Test pattern for an address; inv selects the complemented pass.
  function automatic logic [ram_width-1:0] pattern(
    input logic [addr_size-1:0] a,
    input logic                 inv
  );
    logic [ram_width-1:0] p;
    p = ram_width'(a) + ram_width'(1);
    return inv ? ~p : p;
  endfunction

  // Read-back comparison and the error count it would produce this edge.
  always_comb begin
    mismatch_c       = 1'b0;
    first_mismatch_c = 1'b0;
    err_next_c       = err_count;
    if (cmp_valid && (ram_data_out != cmp_exp)) begin
      mismatch_c       = 1'b1;
      first_mismatch_c = (err_count == '0);
      err_next_c       = err_count + err_width'(1);
    end
  end

  // Controller FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pass_bit     <= 1'b0;
      cmp_valid    <= 1'b0;
      cmp_addr     <= '0;
      cmp_exp      <= '0;
      ram_wr_addr  <= '0;
      ram_data_in  <= '0;
      ram_write_en <= 1'b0;
      ram_rd_addr  <= '0;
      ram_read_en  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail_pass    <= 1'b0;
      fail_addr    <= '0;
      fail_data    <= '0;
      err_count    <= '0;
    end else begin
      done      <= 1'b0;
      cmp_valid <= 1'b0;

      // Result bookkeeping for the read compared at this edge.
      if (mismatch_c) begin
        err_count <= err_next_c;
        if (first_mismatch_c) begin
          fail_pass <= pass_bit;
          fail_addr <= cmp_addr;
          fail_data <= ram_data_out;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            err_count    <= '0;
            fail_pass    <= 1'b0;
            fail_addr    <= '0;
            fail_data    <= '0;
            pass         <= 1'b0;
            busy         <= 1'b1;
            pass_bit     <= 1'b0;
            ram_write_en <= 1'b1;
            ram_wr_addr  <= '0;
            ram_data_in  <= pattern('0, 1'b0);
            state        <= WRITE;
          end
        end

        WRITE: begin
          if (ram_wr_addr == last_addr) begin
            ram_write_en <= 1'b0;
            ram_read_en  <= 1'b1;
            ram_rd_addr  <= '0;
            state        <= READ;
          end else begin
            ram_wr_addr <= ram_wr_addr + addr_size'(1);
            ram_data_in <= pattern(ram_wr_addr + addr_size'(1), pass_bit);
          end
        end

        READ: begin
          cmp_valid <= 1'b1;
          cmp_addr  <= ram_rd_addr;
          cmp_exp   <= pattern(ram_rd_addr, pass_bit);
          if (ram_rd_addr == last_addr) begin
            ram_read_en <= 1'b0;
            state       <= FLUSH;
          end else begin
            ram_rd_addr <= ram_rd_addr + addr_size'(1);
          end
        end

        FLUSH: begin
          if (!pass_bit) begin
            pass_bit     <= 1'b1;
            ram_write_en <= 1'b1;
            ram_wr_addr  <= '0;
            ram_data_in  <= pattern('0, 1'b1);
            state        <= WRITE;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next_c == '0);
            state <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: runs the BIST controller against a behavioural RAM with
// selectable read faults and checks run results through a scoreboard.
module tb_ram_bist_ctrl;

  localparam int unsigned W   = 8;
  localparam int unsigned A   = 4;
  localparam int unsigned D   = 16;
  localparam int          RUN = 2 * (2 * D + 1);

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [A-1:0]   ram_wr_addr;
  logic [W-1:0]   ram_data_in;
  logic           ram_write_en;
  logic [A-1:0]   ram_rd_addr;
  logic           ram_read_en;
  logic [W-1:0]   ram_data_out;
  logic           busy;
  logic           done;
  logic           pass;
  logic           fail_pass;
  logic [A-1:0]   fail_addr;
  logic [W-1:0]   fail_data;
  logic [A+1:0]   err_count;

  int n_cmp = 0;
  int n_bad = 0;
  int fault_mode = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  ram_bist_ctrl #(.ram_width(W), .addr_size(A), .ram_depth(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .ram_wr_addr  (ram_wr_addr),
    .ram_data_in  (ram_data_in),
    .ram_write_en (ram_write_en),
    .ram_rd_addr  (ram_rd_addr),
    .ram_read_en  (ram_read_en),
    .ram_data_out (ram_data_out),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fail_pass    (fail_pass),
    .fail_addr    (fail_addr),
    .fail_data    (fail_data),
    .err_count    (err_count)
  );

  // Behavioural RAM with a one-cycle read latency and injectable read faults.
  logic [W-1:0] mem [D];

  function automatic logic [W-1:0] fault_view(input logic [A-1:0] a, input logic [W-1:0] d);
    case (fault_mode)
      1:       return (a == 4'd5) ? (d & 8'hFE) : d;
      2:       return (a == 4'd3 || a == 4'd9) ? 8'h00 : d;
      3:       return (a == 4'd0) ? 8'h00 : d;
      default: return d;
    endcase
  endfunction

  always @(posedge clk) begin
    if (ram_write_en) mem[ram_wr_addr] <= ram_data_in;
    if (ram_read_en) ram_data_out <= fault_view(ram_rd_addr, mem[ram_rd_addr]);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected write data for the n-th write of a run (0..2*D-1).
  function automatic logic [31:0] exp_pat(input int n);
    int v;
    v = ((n % D) + 1) % 256;
    if (n >= D) v = 255 - v;
    return 32'(v);
  endfunction

  // Per-cycle protocol monitor: exclusivity, address range, write/read order.
  int wcnt = 0;
  int rcnt = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      check("we_re_exclusive", 32'(ram_write_en & ram_read_en), 32'd0);
      check("wr_addr_range", 32'(ram_wr_addr < A'(D - 1) || ram_wr_addr == A'(D - 1)), 32'd1);
      check("rd_addr_range", 32'(ram_rd_addr < A'(D - 1) || ram_rd_addr == A'(D - 1)), 32'd1);
      if (!busy) begin
        wcnt = 0;
        rcnt = 0;
      end else begin
        if (ram_write_en) begin
          check("wr_addr_order", 32'(ram_wr_addr), 32'(wcnt % D));
          check("wr_data", 32'(ram_data_in), exp_pat(wcnt));
          wcnt++;
        end
        if (ram_read_en) begin
          check("rd_addr_order", 32'(ram_rd_addr), 32'(rcnt % D));
          rcnt++;
        end
      end
    end
  end

  typedef struct {
    int fault;
    int xlo;
    int xhi;
    bit done_start;
    bit e_pass;
    int e_err;
    bit e_fp;
    int e_fa;
    int e_fd;
  } vec_t;

  typedef struct {
    bit pass;
    int err;
    bit fp;
    int fa;
    int fd;
  } res_t;

  vec_t vecs[5];
  res_t sbq[$];

  // One complete run: expected result is queued at start, popped at done.
  task automatic run_vec(input vec_t v);
    int   done_k;
    int   busy_cnt;
    int   done_cnt;
    res_t e;
    res_t r;
    fault_mode = v.fault;
    e.pass = v.e_pass;
    e.err  = v.e_err;
    e.fp   = v.e_fp;
    e.fa   = v.e_fa;
    e.fd   = v.e_fd;
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    done_k   = 0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 1; k <= RUN + 12; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_k == 0) done_k = k;
        if (sbq.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          r = sbq.pop_front();
          check("pass", 32'(pass), 32'(r.pass));
          check("err_count", 32'(err_count), 32'(r.err));
          check("fail_pass", 32'(fail_pass), 32'(r.fp));
          check("fail_addr", 32'(fail_addr), 32'(r.fa));
          check("fail_data", 32'(fail_data), 32'(r.fd));
        end
      end
      start = ((k >= v.xlo && k <= v.xhi) ||
               (v.done_start && (k == RUN || k == RUN + 1))) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("done_cycle", 32'(done_k), 32'(RUN + 1));
    check("busy_cycles", 32'(busy_cnt), 32'(RUN));
    check("sb_drained", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    vecs[0] = '{0,  0, -1, 1'b0, 1'b1, 0, 1'b0, 0, 'h00};
    vecs[1] = '{1,  0, -1, 1'b0, 1'b0, 1, 1'b1, 5, 'hF8};
    vecs[2] = '{2,  0, -1, 1'b0, 1'b0, 4, 1'b0, 3, 'h00};
    vecs[3] = '{0, 30, 39, 1'b1, 1'b1, 0, 1'b0, 0, 'h00};
    vecs[4] = '{0,  0, -1, 1'b0, 1'b1, 0, 1'b0, 0, 'h00};

    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_write_en", 32'(ram_write_en), 32'd0);
    check("rst_read_en", 32'(ram_read_en), 32'd0);
    check("rst_wr_addr", 32'(ram_wr_addr), 32'd0);
    check("rst_data_in", 32'(ram_data_in), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_fail_addr", 32'(fail_addr), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset during pass-0 READ, after a mismatch has been counted.
    fault_mode = 3;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 19) begin
        check("mid_read_en", 32'(ram_read_en), 32'd1);
        check("mid_err", 32'(err_count), 32'd1);
      end
      if (k == 20) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    check("mr_write_en", 32'(ram_write_en), 32'd0);
    check("mr_read_en", 32'(ram_read_en), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_err", 32'(err_count), 32'd0);
    check("mr_pass", 32'(pass), 32'd0);
    check("mr_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    check("mr_stays_idle", 32'(busy), 32'd0);
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
